// File: rtl/aes_pkg.sv
// Shared AES round-datapath definitions: state geometry, FSM encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int STATE_W   = 128;
  localparam int BYTE_BITS = 8;
  localparam int ROW_BITS  = 32;
  localparam int COL_BITS  = 32;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mixState_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns transform of one 32-bit column {a0,a1,a2,a3}.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_BITS-1:0] colIn,
  output logic [COL_BITS-1:0] colOut
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = colIn[31:24];
  assign a1 = colIn[23:16];
  assign a2 = colIn[15:8];
  assign a3 = colIn[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a is formed as xtime(a)^a, so each output byte is a pure XOR network.
  assign colOut[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign colOut[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign colOut[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign colOut[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns: one column per clock through a shared mixer, valid/ready on both sides,
// with inLast bypassing the mix for the final round.
module mix_columns_iter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inValid,
  output logic               inReady,
  input  logic [STATE_W-1:0] inState,
  input  logic               inLast,
  output logic               outValid,
  input  logic               outReady,
  output logic [STATE_W-1:0] outState
);

  mixState_t          state, stateNext;
  logic [1:0]         col;
  logic [STATE_W-1:0] work, workNext;
  logic [COL_BITS-1:0] colSel, colMixed;
  logic               accept;

  assign inReady  = rst_n && ((state == IDLE) || ((state == DONE) && outReady));
  assign accept   = inValid && inReady;
  assign outValid = (state == DONE);
  assign outState = work;

  // Gather column col out of the row-major working register.
  always_comb begin
    colSel = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col == c[1:0]) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          colSel[COL_BITS-1-BYTE_BITS*r -: BYTE_BITS] =
            work[STATE_W-1-ROW_BITS*r-BYTE_BITS*c -: BYTE_BITS];
        end
      end
    end
  end

  mix_single_column uMix (
    .colIn  (colSel),
    .colOut (colMixed)
  );

  // A new accept always wins; otherwise BUSY scatters the mixed column back in place.
  always_comb begin
    workNext = work;
    if (accept) begin
      workNext = inState;
    end else if (state == BUSY) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (col == c[1:0]) begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            workNext[STATE_W-1-ROW_BITS*r-BYTE_BITS*c -: BYTE_BITS] =
              colMixed[COL_BITS-1-BYTE_BITS*r -: BYTE_BITS];
          end
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = inLast ? DONE : BUSY;
      BUSY:    if (col == 2'd3) stateNext = DONE;
      DONE:    if (outReady) stateNext = accept ? (inLast ? DONE : BUSY) : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= 2'd0;
      work  <= '0;
    end else begin
      state <= stateNext;
      work  <= workNext;
      if (accept) begin
        col <= 2'd0;
      end else if (state == BUSY) begin
        col <= col + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter against a matrix-form GF(2^8) reference model.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [127:0] inState = '0;
  logic         inLast = 1'b0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [127:0] outState;

  int errors = 0;
  int checks = 0;

  mix_columns_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inState  (inState),
    .inLast   (inLast),
    .outValid (outValid),
    .outReady (outReady),
    .outState (outState)
  );

  always #5 clk = ~clk;

  // Polynomial multiply then long-division reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] coef(input int r, input int k);
    case ((k - r) & 3)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] refMix(input logic [127:0] s, input logic last);
    logic [7:0]   a [4][4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (last) return s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = s[127-32*r-8*c -: 8];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(coef(r, k), a[k][c]);
        o[127-32*r-8*c -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] setCol(input logic [127:0] s, input int c, input logic [31:0] v);
    logic [127:0] o;
    o = s;
    for (int r = 0; r < 4; r++) o[127-32*r-8*c -: 8] = v[31-8*r -: 8];
    return o;
  endfunction

  function automatic logic [127:0] randState();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one state from IDLE, count edges after the accept edge until outValid, then drain it.
  task automatic doTransfer(input logic [127:0] s, input logic last, input bit noise,
                            output logic [127:0] res, output int lat, output logic acc);
    acc = inReady;
    inValid = 1'b1; inState = s; inLast = last; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 20) begin
      if (noise) begin
        inValid = 1'($urandom_range(0, 1));
        inState = randState();
        inLast  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    res = outState;
    inValid = 1'b0; inLast = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outValid got=%b want=0", outValid); end
    checks++; if (outState !== 128'h0) begin errors++; $display("[TB] FAIL reset_outState got=%h want=0", outState); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_inReady_low got=%b want=0", inReady); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_inReady_high got=%b want=1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_outValid got=%b want=0", outValid); end
  endtask

  task automatic test_vectors();
    logic [127:0] s, exp, res;
    int lat;
    logic acc;
    s = '0;
    s = setCol(s, 0, 32'hdb135345);
    s = setCol(s, 1, 32'hf20a225c);
    s = setCol(s, 2, 32'h2d26314c);
    s = setCol(s, 3, 32'h01010101);
    exp = '0;
    exp = setCol(exp, 0, 32'h8e4da1bc);
    exp = setCol(exp, 1, 32'h9fdc589d);
    exp = setCol(exp, 2, 32'h4d7ebdf8);
    exp = setCol(exp, 3, 32'h01010101);
    doTransfer(s, 1'b0, 1'b0, res, lat, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL vec_accept inReady=%b want=1", acc); end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL vec_latency edges=%0d want=4", lat); end
    checks++; if (res !== exp) begin errors++; $display("[TB] FAIL vec_known got=%h want=%h", res, exp); end
    checks++; if (res !== refMix(s, 1'b0)) begin errors++; $display("[TB] FAIL vec_model got=%h want=%h", res, refMix(s, 1'b0)); end
  endtask

  task automatic test_fixed_last();
    logic [127:0] s, res;
    int lat;
    logic acc;
    s = {16{8'hc6}};
    doTransfer(s, 1'b0, 1'b0, res, lat, acc);
    checks++; if (res !== s) begin errors++; $display("[TB] FAIL fixed_point got=%h want=%h", res, s); end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL fixed_latency edges=%0d want=4", lat); end
    doTransfer(s, 1'b1, 1'b0, res, lat, acc);
    checks++; if (res !== s) begin errors++; $display("[TB] FAIL last_passthru got=%h want=%h", res, s); end
    checks++; if (lat != 0) begin errors++; $display("[TB] FAIL last_latency edges=%0d want=0", lat); end
    s = randState();
    doTransfer(s, 1'b1, 1'b0, res, lat, acc);
    checks++; if (res !== s) begin errors++; $display("[TB] FAIL last_random got=%h want=%h", res, s); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vec [3];
    logic [127:0] got [$];
    int acceptCycles [$];
    int sent, acceptsInDone;
    bit doAccept, doOut;
    for (int i = 0; i < 3; i++) vec[i] = randState();
    sent = 0; acceptsInDone = 0;
    inValid = 1'b1; inState = vec[0]; inLast = 1'b0; outReady = 1'b1;
    for (int cyc = 0; cyc < 60 && got.size() < 3; cyc++) begin
      doAccept = inValid && inReady;
      doOut    = outValid && outReady;
      if (doAccept && outValid) acceptsInDone++;
      if (doOut) got.push_back(outState);
      if (doAccept) acceptCycles.push_back(cyc);
      @(posedge clk); #1;
      if (doAccept) begin
        sent++;
        if (sent < 3) inState = vec[sent];
        else inValid = 1'b0;
      end
    end
    checks++; if (got.size() != 3) begin errors++; $display("[TB] FAIL b2b_count got=%0d want=3", got.size()); end
    checks++; if (acceptsInDone != 2) begin errors++; $display("[TB] FAIL b2b_overlap got=%0d want=2", acceptsInDone); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== refMix(vec[i], 1'b0)) begin
        errors++; $display("[TB] FAIL b2b_data%0d got=%h want=%h", i, got[i], refMix(vec[i], 1'b0));
      end
    end
    for (int i = 1; i < acceptCycles.size(); i++) begin
      checks++;
      if (acceptCycles[i] - acceptCycles[i-1] != 5) begin
        errors++; $display("[TB] FAIL b2b_spacing%0d got=%0d want=5", i, acceptCycles[i] - acceptCycles[i-1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_dup got=%b want=0", outValid); end
      @(posedge clk); #1;
    end
    outReady = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] s, exp;
    int wait0, xfers;
    s = randState();
    exp = refMix(s, 1'b0);
    inValid = 1'b1; inState = s; inLast = 1'b0; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    wait0 = 0;
    while (!outValid && wait0 < 20) begin @(posedge clk); #1; wait0++; end
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_reach_done outValid=%b want=1", outValid); end
    inValid = 1'b1; inState = randState();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid cyc%0d got=%b want=1", i, outValid); end
      checks++; if (outState !== exp) begin errors++; $display("[TB] FAIL bp_state cyc%0d got=%h want=%h", i, outState, exp); end
      checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_inReady cyc%0d got=%b want=0", i, inReady); end
    end
    inValid = 1'b0; outReady = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      if (outValid && outReady) xfers++;
      @(posedge clk); #1;
    end
    outReady = 1'b0;
    checks++; if (xfers != 1) begin errors++; $display("[TB] FAIL bp_single_xfer got=%0d want=1", xfers); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] s, exp, res;
    int lat;
    logic acc;
    inValid = 1'b1; inState = randState(); inLast = 1'b0; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outValid got=%b want=0", outValid); end
    checks++; if (outState !== 128'h0) begin errors++; $display("[TB] FAIL rstmid_outState got=%h want=0", outState); end
    rst_n = 1'b1;
    #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_idle inReady=%b want=1", inReady); end
    s = setCol(128'h0, 0, 32'hd4d4d4d5);
    exp = setCol(128'h0, 0, 32'hd5d5d7d6);
    doTransfer(s, 1'b0, 1'b0, res, lat, acc);
    checks++; if (res !== exp) begin errors++; $display("[TB] FAIL rstmid_vector got=%h want=%h", res, exp); end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL rstmid_latency edges=%0d want=4", lat); end
  endtask

  task automatic test_busy_ignores();
    logic [127:0] s, res;
    int lat;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      s = randState();
      doTransfer(s, 1'b0, 1'b1, res, lat, acc);
      checks++; if (res !== refMix(s, 1'b0)) begin errors++; $display("[TB] FAIL busy_ignore%0d got=%h want=%h", i, res, refMix(s, 1'b0)); end
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL busy_latency%0d edges=%0d want=4", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [127:0] s, res;
    logic last, acc;
    int lat;
    for (int i = 0; i < 16; i++) begin
      s = randState();
      last = 1'($urandom_range(0, 1));
      doTransfer(s, last, 1'b1, res, lat, acc);
      checks++; if (res !== refMix(s, last)) begin errors++; $display("[TB] FAIL rand%0d last=%b got=%h want=%h", i, last, res, refMix(s, last)); end
      checks++; if (lat != (last ? 0 : 4)) begin errors++; $display("[TB] FAIL rand_latency%0d edges=%0d want=%0d", i, lat, last ? 0 : 4); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_fixed_last();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_busy_ignores();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
